// File: rtl/carregador_disco_pkg.sv
// Shared definitions for the disk-to-instruction-memory loader:
// FSM state encoding and default bus widths.
package carregador_disco_pkg;

    localparam int ADDR_W_PADRAO     = 26;
    localparam int DATA_W_PADRAO     = 32;
    localparam int MEM_ADDR_W_PADRAO = 10;
    localparam int DISK_SIZE_PADRAO  = 16;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LE      = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/carregador_disco_if.sv
// Loader bus: start/range request, disk read port, memory write port and status.
interface carregador_disco_if
    import carregador_disco_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_PADRAO,
    parameter int DATA_W     = DATA_W_PADRAO,
    parameter int MEM_ADDR_W = MEM_ADDR_W_PADRAO
) ();

    logic                  iniciar;
    logic [ADDR_W-1:0]     origem;
    logic [MEM_ADDR_W-1:0] destino;
    logic [ADDR_W-1:0]     quantidade;
    logic [ADDR_W-1:0]     disk_pc;
    logic [DATA_W-1:0]     disk_instrucao;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0]     mem_dado;
    logic                  ocupado;
    logic                  concluido;
    logic                  erro;

    // slave is the loader itself; master is whoever requests transfers and hosts disk/memory
    modport slave (
        input  iniciar, origem, destino, quantidade, disk_instrucao,
        output disk_pc, mem_we, mem_endereco, mem_dado, ocupado, concluido, erro
    );

    modport master (
        output iniciar, origem, destino, quantidade, disk_instrucao,
        input  disk_pc, mem_we, mem_endereco, mem_dado, ocupado, concluido, erro
    );

endinterface

// File: rtl/carregador_disco.sv
// Boot/DMA loader: copies a contiguous range of disk words into instruction memory,
// one word per LATENCIA+1 cycles, with range checking against the disk size.
module carregador_disco
    import carregador_disco_pkg::*;
#(
    parameter int DISK_SIZE  = DISK_SIZE_PADRAO,
    parameter int ADDR_W     = ADDR_W_PADRAO,
    parameter int DATA_W     = DATA_W_PADRAO,
    parameter int MEM_ADDR_W = MEM_ADDR_W_PADRAO,
    parameter int LATENCIA   = 1
) (
    input  logic               clock,
    input  logic               reset,
    carregador_disco_if.slave  bus
);

    localparam int ESP_W = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
    localparam logic [ESP_W-1:0]  ULTIMA = ESP_W'(LATENCIA - 1);
    localparam logic [ADDR_W:0]   LIMITE = (ADDR_W + 1)'(DISK_SIZE);

    estado_t               estado;
    logic [ADDR_W-1:0]     src;
    logic [MEM_ADDR_W-1:0] dst;
    logic [ADDR_W-1:0]     rest;
    logic [ESP_W-1:0]      espera;
    logic [DATA_W-1:0]     dado;
    logic [ADDR_W-1:0]     pc;
    logic                  we;
    logic                  ocup;
    logic                  conc;
    logic                  err;

    // One extra bit so origem+quantidade cannot wrap past the disk limit
    function automatic logic fora_do_disco(input logic [ADDR_W-1:0] o,
                                           input logic [ADDR_W-1:0] q);
        logic [ADDR_W:0] fim;
        fim = {1'b0, o} + {1'b0, q};
        return fim > LIMITE;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            src    <= '0;
            dst    <= '0;
            rest   <= '0;
            espera <= '0;
            dado   <= '0;
            pc     <= '0;
            we     <= 1'b0;
            ocup   <= 1'b0;
            conc   <= 1'b0;
            err    <= 1'b0;
        end else begin
            we   <= 1'b0;
            conc <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        err <= 1'b0;
                        if (bus.quantidade == '0) begin
                            estado <= FIM;
                            conc   <= 1'b1;
                        end else if (fora_do_disco(bus.origem, bus.quantidade)) begin
                            err    <= 1'b1;
                            estado <= FIM;
                            conc   <= 1'b1;
                        end else begin
                            src    <= bus.origem;
                            dst    <= bus.destino;
                            rest   <= bus.quantidade;
                            pc     <= bus.origem;
                            espera <= '0;
                            ocup   <= 1'b1;
                            estado <= LE;
                        end
                    end
                end
                LE: begin
                    // Disk data is sampled on the last cycle of the hold window
                    if (espera == ULTIMA) begin
                        dado   <= bus.disk_instrucao;
                        we     <= 1'b1;
                        estado <= ESCREVE;
                    end else begin
                        espera <= espera + ESP_W'(1);
                    end
                end
                ESCREVE: begin
                    src  <= src + ADDR_W'(1);
                    dst  <= dst + MEM_ADDR_W'(1);
                    rest <= rest - ADDR_W'(1);
                    if (rest == ADDR_W'(1)) begin
                        ocup   <= 1'b0;
                        conc   <= 1'b1;
                        estado <= FIM;
                    end else begin
                        pc     <= src + ADDR_W'(1);
                        espera <= '0;
                        estado <= LE;
                    end
                end
                FIM: begin
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.disk_pc      = pc;
    assign bus.mem_we       = we;
    assign bus.mem_endereco = dst;
    assign bus.mem_dado     = dado;
    assign bus.ocupado      = ocup;
    assign bus.concluido    = conc;
    assign bus.erro         = err;

endmodule

// File: tb/tb_carregador_disco.sv
// Directed bench for carregador_disco: a 4-word-memory instance (LATENCIA=1) driven
// from a vector table, and a LATENCIA=3 instance checked cycle by cycle.
module tb_carregador_disco;

    logic clock;
    logic reset;

    int n_chk  = 0;
    int n_fail = 0;

    carregador_disco_if #(.ADDR_W(26), .DATA_W(32), .MEM_ADDR_W(2))  ba ();
    carregador_disco_if #(.ADDR_W(26), .DATA_W(32), .MEM_ADDR_W(10)) bb ();

    carregador_disco #(.DISK_SIZE(16), .ADDR_W(26), .DATA_W(32), .MEM_ADDR_W(2), .LATENCIA(1))
        dut_a (.clock(clock), .reset(reset), .bus(ba));
    carregador_disco #(.DISK_SIZE(16), .ADDR_W(26), .DATA_W(32), .MEM_ADDR_W(10), .LATENCIA(3))
        dut_b (.clock(clock), .reset(reset), .bus(bb));

    // 16-word disk ROM: disk[i] = A000_0000 + i
    assign ba.disk_instrucao = 32'hA000_0000 + 32'(ba.disk_pc);
    assign bb.disk_instrucao = 32'hA000_0000 + 32'(bb.disk_pc);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t wq_a[$];

    always @(posedge clock) begin
        if (ba.mem_we) wq_a.push_back('{ba.mem_endereco, ba.mem_dado});
    end

    typedef struct {
        logic [25:0] origem;
        logic [1:0]  destino;
        logic [25:0] quant;
        logic        erro;
        int          lat;
        int          nw;
    } vec_t;

    vec_t vt[9];
    logic prev_err;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_a(input int id, input vec_t v);
        int lat;
        lat = 0;
        check($sformatf("v%0d erro_sticky", id), ba.erro, prev_err);
        wq_a.delete();
        ba.origem     = v.origem;
        ba.destino    = v.destino;
        ba.quantidade = v.quant;
        ba.iniciar    = 1'b1;
        @(posedge clock);
        #1 ba.iniciar = 1'b0;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            @(negedge clock);
            if (c == 1) check($sformatf("v%0d ocupado", id), ba.ocupado, (v.nw > 0) ? 1 : 0);
            if (ba.concluido) begin
                lat = c;
                check($sformatf("v%0d erro", id), ba.erro, v.erro);
                check($sformatf("v%0d ocupado_fim", id), ba.ocupado, 0);
            end
        end
        check($sformatf("v%0d latencia", id), lat, v.lat);
        check($sformatf("v%0d n_escritas", id), wq_a.size(), v.nw);
        for (int i = 0; i < wq_a.size() && i < v.nw; i++) begin
            check($sformatf("v%0d end[%0d]", id, i), wq_a[i].addr, 2'(v.destino + 2'(i)));
            check($sformatf("v%0d dado[%0d]", id, i), wq_a[i].data,
                  32'hA000_0000 + 32'(v.origem) + 32'(i));
        end
        prev_err = v.erro;
        @(negedge clock);
    endtask

    initial begin
        int base;
        int lat;
        vt[0] = '{26'd0,         2'd0, 26'd3,  1'b0, 7,  3};
        vt[1] = '{26'd14,        2'd0, 26'd3,  1'b1, 1,  0};
        vt[2] = '{26'd5,         2'd1, 26'd0,  1'b0, 1,  0};
        vt[3] = '{26'd4,         2'd3, 26'd2,  1'b0, 5,  2};
        vt[4] = '{26'd13,        2'd2, 26'd3,  1'b0, 7,  3};
        vt[5] = '{26'd16,        2'd0, 26'd1,  1'b1, 1,  0};
        vt[6] = '{26'd15,        2'd0, 26'd1,  1'b0, 3,  1};
        vt[7] = '{26'h3FF_FFFF,  2'd0, 26'd2,  1'b1, 1,  0};
        vt[8] = '{26'd0,         2'd1, 26'd16, 1'b0, 33, 16};

        reset = 1'b0;
        ba.iniciar = 1'b0; ba.origem = '0; ba.destino = '0; ba.quantidade = '0;
        bb.iniciar = 1'b0; bb.origem = '0; bb.destino = '0; bb.quantidade = '0;
        prev_err = 1'b0;
        repeat (2) @(negedge clock);
        check("reset disk_pc", ba.disk_pc, 0);
        check("reset mem_we", ba.mem_we, 0);
        check("reset ocupado", ba.ocupado, 0);
        check("reset concluido", ba.concluido, 0);
        check("reset erro", ba.erro, 0);
        check("reset b mem_we", bb.mem_we, 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 9; i++) run_a(i, vt[i]);

        // Reset during a 5-word copy, right after the second write
        wq_a.delete();
        ba.origem = 26'd0; ba.destino = 2'd0; ba.quantidade = 26'd5; ba.iniciar = 1'b1;
        @(posedge clock);
        #1 ba.iniciar = 1'b0;
        for (int c = 0; c < 50 && wq_a.size() < 2; c++) @(negedge clock);
        check("rst_meio escritas_antes", wq_a.size(), 2);
        reset = 1'b0;
        #1;
        check("rst_meio disk_pc", ba.disk_pc, 0);
        check("rst_meio mem_we", ba.mem_we, 0);
        check("rst_meio mem_endereco", ba.mem_endereco, 0);
        check("rst_meio mem_dado", ba.mem_dado, 0);
        check("rst_meio ocupado", ba.ocupado, 0);
        check("rst_meio concluido", ba.concluido, 0);
        check("rst_meio erro", ba.erro, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_meio escritas_depois", wq_a.size(), 2);
        prev_err = 1'b0;
        run_a(9, '{26'd1, 2'd2, 26'd2, 1'b0, 5, 2});

        // LATENCIA=3: disk_pc held 3 cycles per word, second start ignored
        bb.origem = 26'd2; bb.destino = 10'd5; bb.quantidade = 26'd2; bb.iniciar = 1'b1;
        @(posedge clock);
        #1 bb.iniciar = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clock);
            if (bb.concluido) lat = c;
            if (c <= 8) begin
                base = (c - 1) / 4;
                check($sformatf("lat3 disk_pc c%0d", c), bb.disk_pc, 2 + base);
                check($sformatf("lat3 mem_we c%0d", c), bb.mem_we, (c % 4 == 0) ? 1 : 0);
                if (c % 4 == 0) begin
                    check($sformatf("lat3 end c%0d", c), bb.mem_endereco, 5 + base);
                    check($sformatf("lat3 dado c%0d", c), bb.mem_dado, 32'hA000_0002 + 32'(base));
                end
            end
            if (c == 2) begin
                bb.origem = 26'd9; bb.destino = 10'd0; bb.quantidade = 26'd1; bb.iniciar = 1'b1;
            end else begin
                bb.iniciar = 1'b0;
            end
        end
        check("lat3 latencia", lat, 9);
        check("lat3 disk_pc_fim", bb.disk_pc, 3);
        // Start request during FIM must be dropped
        bb.origem = 26'd0; bb.destino = 10'd0; bb.quantidade = 26'd1; bb.iniciar = 1'b1;
        @(negedge clock);
        bb.iniciar = 1'b0;
        check("fim_ignora ocupado", bb.ocupado, 0);
        check("fim_ignora concluido", bb.concluido, 0);
        @(negedge clock);
        check("fim_ignora ocupado2", bb.ocupado, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
